// File: rtl/ddr4_memtest_pkg.sv
// Shared types and helpers for the DDR4 AXI memory tester.
// Contents: AXI channel/request/response structs, FSM state enum,
// response/burst encodings and the address-derived data pattern function.
package ddr4_memtest_pkg;

  localparam int MT_ADDR_W = 64;
  localparam int MT_DATA_W = 64;
  localparam int MT_ID_W   = 4;
  localparam int MT_USER_W = 1;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW,
    ST_WR_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_DONE
  } memtest_state_e;

  typedef struct packed {
    logic [MT_ID_W-1:0]   id;
    logic [MT_ADDR_W-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [MT_USER_W-1:0] user;
  } memtest_ax_chan_t;

  typedef struct packed {
    logic [MT_DATA_W-1:0]   data;
    logic [MT_DATA_W/8-1:0] strb;
    logic                   last;
    logic [MT_USER_W-1:0]   user;
  } memtest_w_chan_t;

  typedef struct packed {
    logic [MT_ID_W-1:0]   id;
    logic [1:0]           resp;
    logic [MT_USER_W-1:0] user;
  } memtest_b_chan_t;

  typedef struct packed {
    logic [MT_ID_W-1:0]   id;
    logic [MT_DATA_W-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [MT_USER_W-1:0] user;
  } memtest_r_chan_t;

  typedef struct packed {
    memtest_ax_chan_t aw;
    logic             aw_valid;
    memtest_w_chan_t  w;
    logic             w_valid;
    logic             b_ready;
    memtest_ax_chan_t ar;
    logic             ar_valid;
    logic             r_ready;
  } memtest_req_t;

  typedef struct packed {
    logic            aw_ready;
    logic            ar_ready;
    logic            w_ready;
    logic            b_valid;
    memtest_b_chan_t b;
    logic            r_valid;
    memtest_r_chan_t r;
  } memtest_resp_t;

  // Each 32-bit lane carries the low address word XOR seed XOR lane index,
  // so neighbouring lanes and neighbouring beats never share a value.
  function automatic logic [MT_DATA_W-1:0] memtest_pattern(input logic [31:0] addr,
                                                           input logic [31:0] seed);
    logic [MT_DATA_W-1:0] pat;
    pat = '0;
    for (int i = 0; i < MT_DATA_W / 32; i++) begin
      pat[i*32 +: 32] = addr ^ seed ^ 32'(i);
    end
    return pat;
  endfunction

endpackage

// File: rtl/ddr4_memtest_addrgen.sv
// Burst/beat counters and address generation for the memory tester.
// The same counters walk the region once for writes and once for reads.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   load_i                latch base/num_bursts and rewind (test start)
//   restart_i             rewind to the latched base (start of read phase)
//   burst_adv_i           move to the next burst
//   beat_adv_i            move to the next beat within the burst
//   base_addr_i           region base; low burst-offset bits are dropped
//   num_bursts_i          number of bursts in the region
//   burst_addr_o          start address of the current burst
//   beat_addr_o           address of the current beat
//   last_beat_o           current beat is the final beat of the burst
//   last_burst_o          current burst is the final burst of the region
module ddr4_memtest_addrgen #(
  parameter int AddrWidth = 64,
  parameter int CntWidth  = 32,
  parameter int BurstLen  = 16,
  parameter int BeatBytes = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 restart_i,
  input  logic                 burst_adv_i,
  input  logic                 beat_adv_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [CntWidth-1:0]  num_bursts_i,
  output logic [AddrWidth-1:0] burst_addr_o,
  output logic [AddrWidth-1:0] beat_addr_o,
  output logic                 last_beat_o,
  output logic                 last_burst_o
);

  localparam logic [AddrWidth-1:0] BEAT_INC  = AddrWidth'(BeatBytes);
  localparam logic [AddrWidth-1:0] BURST_INC = AddrWidth'(BurstLen * BeatBytes);

  logic [AddrWidth-1:0] base_q;
  logic [AddrWidth-1:0] base_aligned;
  logic [CntWidth-1:0]  num_q;
  logic [CntWidth-1:0]  burst_idx;
  logic [7:0]           beat_idx;

  // Aligning the base to the burst size keeps every burst inside one 4 KiB page.
  assign base_aligned = base_addr_i & ~(BURST_INC - AddrWidth'(1));
  assign last_beat_o  = (beat_idx == 8'(BurstLen - 1));
  assign last_burst_o = (burst_idx == num_q - CntWidth'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q       <= '0;
      num_q        <= '0;
      burst_idx    <= '0;
      beat_idx     <= '0;
      burst_addr_o <= '0;
      beat_addr_o  <= '0;
    end else if (load_i) begin
      base_q       <= base_aligned;
      num_q        <= num_bursts_i;
      burst_idx    <= '0;
      beat_idx     <= '0;
      burst_addr_o <= base_aligned;
      beat_addr_o  <= base_aligned;
    end else if (restart_i) begin
      burst_idx    <= '0;
      beat_idx     <= '0;
      burst_addr_o <= base_q;
      beat_addr_o  <= base_q;
    end else if (burst_adv_i) begin
      burst_idx    <= burst_idx + CntWidth'(1);
      beat_idx     <= '0;
      burst_addr_o <= burst_addr_o + BURST_INC;
      beat_addr_o  <= burst_addr_o + BURST_INC;
    end else if (beat_adv_i) begin
      beat_idx    <= last_beat_o ? 8'd0 : beat_idx + 8'd1;
      beat_addr_o <= beat_addr_o + BEAT_INC;
    end
  end

endmodule

// File: rtl/ddr4_axi_memtest.sv
// AXI4 memory tester for DDR4 bring-up: writes an address-derived pattern over
// a region in INCR bursts, reads it back and counts mismatching beats and
// non-OKAY responses. One burst outstanding; all writes finish before reads.
// Optional build macro DDR4_MEMTEST_PERF_EN adds write/read phase cycle counters.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               begin a test (only honoured while idle)
//   base_addr_i           region base, num_bursts_i region size in bursts
//   seed_i                pattern seed
//   busy_o, done_o        test running / one-cycle completion pulse
//   pass_o                last test saw no errors
//   err_count_o           saturating error count
//   first_err_addr_o      address of the first error
//   mst_req_o/mst_resp_i  AXI master port
//   wr_cycles_o/rd_cycles_o  (perf build only) cycles spent in each phase
module ddr4_axi_memtest
  import ddr4_memtest_pkg::*;
#(
  parameter int  AddrWidth = MT_ADDR_W,
  parameter int  DataWidth = MT_DATA_W,
  parameter int  IdWidth   = MT_ID_W,
  parameter int  BurstLen  = 16,
  parameter int  CntWidth  = 32,
  parameter type req_t     = memtest_req_t,
  parameter type resp_t    = memtest_resp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [CntWidth-1:0]  num_bursts_i,
  input  logic [31:0]          seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CntWidth-1:0]  err_count_o,
  output logic [AddrWidth-1:0] first_err_addr_o,
  output req_t                 mst_req_o,
  input  resp_t                mst_resp_i
`ifdef DDR4_MEMTEST_PERF_EN
  ,
  output logic [CntWidth-1:0]  wr_cycles_o,
  output logic [CntWidth-1:0]  rd_cycles_o
`endif
);

  localparam int BEAT_BYTES = DataWidth / 8;
  localparam int AXI_SIZE   = $clog2(BEAT_BYTES);

  memtest_state_e state;

  logic aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
  logic [31:0] seed_q;

  logic [AddrWidth-1:0] burst_addr, beat_addr;
  logic                 last_beat, last_burst;
  logic                 load, restart, burst_adv, beat_adv;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [DataWidth-1:0] beat_pattern;
  logic r_data_bad, r_resp_bad, r_last_bad, b_resp_bad;

  logic [1:0]           err_inc;
  logic [AddrWidth-1:0] err_addr;
  logic [CntWidth:0]    err_sum;
  logic [CntWidth-1:0]  err_next;
  logic                 first_err_en;

  assign aw_hs = aw_valid_q & mst_resp_i.aw_ready;
  assign w_hs  = w_valid_q  & mst_resp_i.w_ready;
  assign b_hs  = b_ready_q  & mst_resp_i.b_valid;
  assign ar_hs = ar_valid_q & mst_resp_i.ar_ready;
  assign r_hs  = r_ready_q  & mst_resp_i.r_valid;

  assign load      = (state == ST_IDLE) && start_i;
  assign restart   = b_hs && last_burst;
  assign burst_adv = (b_hs && !last_burst) || (r_hs && last_beat && !last_burst);
  assign beat_adv  = w_hs || r_hs;

  ddr4_memtest_addrgen #(
    .AddrWidth (AddrWidth),
    .CntWidth  (CntWidth),
    .BurstLen  (BurstLen),
    .BeatBytes (BEAT_BYTES)
  ) u_addrgen (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (load),
    .restart_i    (restart),
    .burst_adv_i  (burst_adv),
    .beat_adv_i   (beat_adv),
    .base_addr_i  (base_addr_i),
    .num_bursts_i (num_bursts_i),
    .burst_addr_o (burst_addr),
    .beat_addr_o  (beat_addr),
    .last_beat_o  (last_beat),
    .last_burst_o (last_burst)
  );

  // Write data and read expectation come from the same registered beat address,
  // so W payload stays stable for as long as the beat is stalled.
  assign beat_pattern = memtest_pattern(beat_addr[31:0], seed_q);

  assign r_data_bad = (mst_resp_i.r.data != beat_pattern);
  assign r_resp_bad = (mst_resp_i.r.resp != AXI_RESP_OKAY);
  assign r_last_bad = (mst_resp_i.r.last != last_beat);
  assign b_resp_bad = (mst_resp_i.b.resp != AXI_RESP_OKAY);

  // A bad beat and a misplaced RLAST are independent faults, so one R beat can add two.
  always_comb begin
    err_inc  = 2'd0;
    err_addr = burst_addr;
    if (b_hs && b_resp_bad) begin
      err_inc = 2'd1;
    end
    if (r_hs) begin
      err_inc  = {1'b0, r_data_bad | r_resp_bad} + {1'b0, r_last_bad};
      err_addr = beat_addr;
    end
  end

  assign err_sum      = {1'b0, err_count_o} + {{(CntWidth-1){1'b0}}, err_inc};
  assign err_next     = err_sum[CntWidth] ? '1 : err_sum[CntWidth-1:0];
  assign first_err_en = (err_count_o == '0) && (err_inc != 2'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      aw_valid_q       <= 1'b0;
      w_valid_q        <= 1'b0;
      b_ready_q        <= 1'b0;
      ar_valid_q       <= 1'b0;
      r_ready_q        <= 1'b0;
      seed_q           <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      err_count_o      <= '0;
      first_err_addr_o <= '0;
    end else begin
      done_o      <= 1'b0;
      err_count_o <= err_next;
      if (first_err_en) begin
        first_err_addr_o <= err_addr;
      end
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            seed_q           <= seed_i;
            err_count_o      <= '0;
            first_err_addr_o <= '0;
            pass_o           <= 1'b0;
            busy_o           <= 1'b1;
            if (num_bursts_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
              pass_o <= 1'b1;
            end else begin
              state      <= ST_WR_AW;
              aw_valid_q <= 1'b1;
            end
          end
        end
        ST_WR_AW: begin
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b1;
            state      <= ST_WR_W;
          end
        end
        ST_WR_W: begin
          if (w_hs && last_beat) begin
            w_valid_q <= 1'b0;
            b_ready_q <= 1'b1;
            state     <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (b_hs) begin
            b_ready_q <= 1'b0;
            if (last_burst) begin
              ar_valid_q <= 1'b1;
              state      <= ST_RD_AR;
            end else begin
              aw_valid_q <= 1'b1;
              state      <= ST_WR_AW;
            end
          end
        end
        ST_RD_AR: begin
          if (ar_hs) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (r_hs && last_beat) begin
            r_ready_q <= 1'b0;
            if (last_burst) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
              pass_o <= (err_next == '0);
            end else begin
              ar_valid_q <= 1'b1;
              state      <= ST_RD_AR;
            end
          end
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw.id    = MT_ID_W'({IdWidth{1'b0}});
    mst_req_o.aw.addr  = burst_addr;
    mst_req_o.aw.len   = 8'(BurstLen - 1);
    mst_req_o.aw.size  = 3'(AXI_SIZE);
    mst_req_o.aw.burst = AXI_BURST_INCR;
    mst_req_o.aw.cache = 4'b0011;
    mst_req_o.aw_valid = aw_valid_q;
    mst_req_o.w.data   = beat_pattern;
    mst_req_o.w.strb   = '1;
    mst_req_o.w.last   = last_beat;
    mst_req_o.w_valid  = w_valid_q;
    mst_req_o.b_ready  = b_ready_q;
    mst_req_o.ar       = mst_req_o.aw;
    mst_req_o.ar_valid = ar_valid_q;
    mst_req_o.r_ready  = r_ready_q;
  end

  logic unused_resp;
  assign unused_resp = ^{mst_resp_i.b.id, mst_resp_i.b.user, mst_resp_i.r.id, mst_resp_i.r.user};

`ifdef DDR4_MEMTEST_PERF_EN
  logic wr_phase, rd_phase;
  assign wr_phase = (state == ST_WR_AW) || (state == ST_WR_W) || (state == ST_WR_B);
  assign rd_phase = (state == ST_RD_AR) || (state == ST_RD_R);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cycles_o <= '0;
      rd_cycles_o <= '0;
    end else if (load) begin
      wr_cycles_o <= '0;
      rd_cycles_o <= '0;
    end else begin
      if (wr_phase && (wr_cycles_o != '1)) wr_cycles_o <= wr_cycles_o + CntWidth'(1);
      if (rd_phase && (rd_cycles_o != '1)) rd_cycles_o <= rd_cycles_o + CntWidth'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ddr4_axi_memtest.sv
// Self-checking bench for ddr4_axi_memtest: behavioural AXI slave memory with
// optional backpressure, read bit-flip and SLVERR injection; expected AW/AR
// addresses and W data are queued at test start and popped on each handshake.
module tb_ddr4_axi_memtest;
  import ddr4_memtest_pkg::*;

  localparam int BL      = 16;
  localparam int BEAT_B  = 8;
  localparam int BURST_B = BL * BEAT_B;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] base;
  logic [31:0] nb;
  logic [31:0] seed;
  logic        busy, done, pass;
  logic [31:0] err_cnt;
  logic [63:0] first_err;
`ifdef DDR4_MEMTEST_PERF_EN
  logic [31:0] wr_cycles, rd_cycles;
`endif
  memtest_req_t  req;
  memtest_resp_t resp;

  always #5 clk = ~clk;

  ddr4_axi_memtest dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .base_addr_i      (base),
    .num_bursts_i     (nb),
    .seed_i           (seed),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_count_o      (err_cnt),
    .first_err_addr_o (first_err),
    .mst_req_o        (req),
    .mst_resp_i       (resp)
`ifdef DDR4_MEMTEST_PERF_EN
    ,
    .wr_cycles_o      (wr_cycles),
    .rd_cycles_o      (rd_cycles)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
  endtask

  // scoreboard
  logic [63:0] exp_aw[$];
  logic [63:0] exp_ar[$];
  logic [63:0] exp_w[$];

  function automatic logic [63:0] model_word(input logic [63:0] a, input logic [31:0] s);
    logic [31:0] x;
    x = a[31:0] ^ s;
    return {x ^ 32'd1, x};
  endfunction

  task automatic push_expect(input logic [63:0] b, input logic [31:0] n, input logic [31:0] s);
    logic [63:0] ab, a;
    ab = b & ~64'(BURST_B - 1);
    for (int k = 0; k < int'(n); k++) begin
      a = ab + 64'(k) * 64'(BURST_B);
      exp_aw.push_back(a);
      exp_ar.push_back(a);
      for (int j = 0; j < BL; j++) exp_w.push_back(model_word(a + 64'(j * BEAT_B), s));
    end
  endtask

  // slave memory state
  logic [63:0] mem [logic [63:0]];
  bit          bp_en = 0;
  bit          flip_en = 0;
  logic [63:0] flip_addr = '0;
  int          slverr_idx = -1;
  int          b_cnt, b_pending, aw_hs_cnt, w_hs_cnt, ar_hs_cnt, done_cnt;
  bit          valid_seen;
  logic [63:0] w_addr, r_addr;
  int          w_beat, r_beat;
  bit          r_active, b_hs_q, r_hs_q;
  bit          aw_stall, w_stall, ar_stall;
  logic [63:0] aw_prev, w_prev, ar_prev;

  function automatic bit draw();
    return !bp_en || ($urandom_range(0, 9) >= 3);
  endfunction

  initial begin : axi_slave
    logic [63:0] rd;
    resp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        resp = '0;
        b_hs_q = 0; r_hs_q = 0; b_pending = 0; r_active = 0;
        w_beat = 0; r_beat = 0; aw_stall = 0; w_stall = 0; ar_stall = 0;
      end else begin
        if (b_hs_q) resp.b_valid = 1'b0;
        if (r_hs_q) resp.r_valid = 1'b0;
        if (req.aw_valid || req.w_valid || req.ar_valid || req.b_ready || req.r_ready) valid_seen = 1;
        if (done) done_cnt++;
        if (aw_stall) begin
          check("aw_hold", req.aw_valid, 1);
          check("aw_stable", req.aw.addr, aw_prev);
        end
        if (w_stall) begin
          check("w_hold", req.w_valid, 1);
          check("w_stable", req.w.data, w_prev);
        end
        if (ar_stall) begin
          check("ar_hold", req.ar_valid, 1);
          check("ar_stable", req.ar.addr, ar_prev);
        end
        resp.aw_ready = draw();
        resp.w_ready  = draw();
        resp.ar_ready = draw();
        if (!resp.b_valid && b_pending > 0 && draw()) begin
          resp.b_valid = 1'b1;
          resp.b.resp  = (b_cnt == slverr_idx) ? 2'b10 : 2'b00;
        end
        if (!resp.r_valid && r_active && draw()) begin
          rd = mem.exists(r_addr) ? mem[r_addr] : 64'h0;
          if (flip_en && r_addr == flip_addr) rd[0] = ~rd[0];
          resp.r_valid = 1'b1;
          resp.r.data  = rd;
          resp.r.resp  = 2'b00;
          resp.r.last  = (r_beat == BL - 1);
        end
        // handshakes that the coming posedge completes
        if (req.aw_valid && resp.aw_ready) begin
          aw_hs_cnt++;
          check("aw_queue", exp_aw.size() != 0, 1);
          if (exp_aw.size() != 0) check("aw_addr", req.aw.addr, exp_aw.pop_front());
          check("aw_len", req.aw.len, BL - 1);
          check("aw_size", req.aw.size, 3);
          check("aw_burst", req.aw.burst, 1);
          check("aw_cache", req.aw.cache, 4'b0011);
          w_addr = req.aw.addr;
          w_beat = 0;
        end
        aw_stall = req.aw_valid && !resp.aw_ready;
        aw_prev  = req.aw.addr;
        if (req.w_valid && resp.w_ready) begin
          w_hs_cnt++;
          check("w_queue", exp_w.size() != 0, 1);
          if (exp_w.size() != 0) check("w_data", req.w.data, exp_w.pop_front());
          check("w_last", req.w.last, w_beat == BL - 1);
          check("w_strb", req.w.strb, 8'hFF);
          mem[w_addr + 64'(w_beat * BEAT_B)] = req.w.data;
          if (w_beat == BL - 1) begin
            b_pending++;
            w_beat = 0;
          end else w_beat++;
        end
        w_stall = req.w_valid && !resp.w_ready;
        w_prev  = req.w.data;
        b_hs_q = resp.b_valid && req.b_ready;
        if (b_hs_q) begin
          b_pending--;
          b_cnt++;
        end
        r_hs_q = resp.r_valid && req.r_ready;
        if (r_hs_q) begin
          r_addr = r_addr + 64'(BEAT_B);
          if (r_beat == BL - 1) begin
            r_active = 0;
            r_beat = 0;
          end else r_beat++;
        end
        if (req.ar_valid && resp.ar_ready) begin
          ar_hs_cnt++;
          check("ar_queue", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) check("ar_addr", req.ar.addr, exp_ar.pop_front());
          check("ar_len", req.ar.len, BL - 1);
          r_active = 1;
          r_addr = req.ar.addr;
          r_beat = 0;
        end
        ar_stall = req.ar_valid && !resp.ar_ready;
        ar_prev  = req.ar.addr;
      end
    end
  end

  task automatic clear_expect();
    exp_aw.delete();
    exp_ar.delete();
    exp_w.delete();
  endtask

  task automatic run_test(input string name, input logic [63:0] b, input logic [31:0] n,
                          input logic [31:0] s, input logic [31:0] e_err,
                          input logic [63:0] e_first, input logic e_pass,
                          input bit disturb, output int cyc);
    clear_expect();
    push_expect(b, n, s);
    aw_hs_cnt = 0; w_hs_cnt = 0; ar_hs_cnt = 0; done_cnt = 0; b_cnt = 0; valid_seen = 0;
    @(negedge clk); #1;
    base = b; nb = n; seed = s; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; base = '0; nb = '0; seed = '0;
    check({name, "_busy"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk); #1;
      cyc++;
      if (disturb && cyc == 20) begin
        check({name, "_busy_restart"}, busy, 1);
        start = 1'b1; base = 64'h8000; nb = 9; seed = 32'h1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({name, "_done"}, done, 1);
    check({name, "_err"}, err_cnt, e_err);
    check({name, "_first"}, first_err, e_first);
    check({name, "_pass"}, pass, e_pass);
    @(negedge clk); #1;
    check({name, "_done_pulse"}, done, 0);
    check({name, "_idle"}, busy, 0);
    check({name, "_pass_sticky"}, pass, e_pass);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_aw_cnt"}, aw_hs_cnt, n);
    check({name, "_w_cnt"}, w_hs_cnt, n * BL);
    check({name, "_ar_cnt"}, ar_hs_cnt, n);
    check({name, "_q_empty"}, exp_aw.size() + exp_ar.size() + exp_w.size(), 0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_aw_v"}, req.aw_valid, 0);
    check({name, "_w_v"}, req.w_valid, 0);
    check({name, "_ar_v"}, req.ar_valid, 0);
    check({name, "_b_r"}, req.b_ready, 0);
    check({name, "_r_r"}, req.r_ready, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin : main
    int cyc;
    rst = 1'b1; start = 1'b0; base = '0; nb = '0; seed = '0;
    repeat (3) @(negedge clk);
    #1;
    check_quiet("rst");
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_first", first_err, 0);
    rst = 1'b0;

    run_test("t1", 64'h1000, 4, 32'hA5A5A5A5, 0, 0, 1, 0, cyc);

    flip_en = 1; flip_addr = 64'h1040;
    run_test("t2", 64'h1000, 4, 32'hA5A5A5A5, 1, 64'h1040, 0, 0, cyc);
    flip_en = 0;

    run_test("t3", 64'h1000, 0, 32'hA5A5A5A5, 0, 0, 1, 0, cyc);
    check("t3_latency", cyc, 0);
    check("t3_no_valid", valid_seen, 0);

    bp_en = 1;
    run_test("t4", 64'h1000_0013, 4, 32'h0F0F_1234, 0, 0, 1, 0, cyc);
    bp_en = 0;

    slverr_idx = 1;
    run_test("t5", 64'h1000, 4, 32'hA5A5A5A5, 1, 64'h1000 + 64'(BURST_B), 0, 1, cyc);
    slverr_idx = -1;

    clear_expect();
    push_expect(64'h1000, 4, 32'hA5A5A5A5);
    @(negedge clk); #1;
    base = 64'h1000; nb = 4; seed = 32'hA5A5A5A5; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!req.w_valid && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("t6_in_wr_w", req.w_valid, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check_quiet("t6_rst");
    rst = 1'b0;
    clear_expect();
    run_test("t6", 64'h1000, 4, 32'hA5A5A5A5, 0, 0, 1, 0, cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
